// File: rtl/uart_tx_frame_engine.sv
// Parametrised UART transmit engine: frame FSM, baud divider, shift register and
// parity generator, with a valid/ready handshake that allows gap-free back-to-back frames.
module uart_tx_frame_engine #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shift_reg;
  logic                parity_bit;
  logic                bit_end;
  logic                frame_end;
  logic                accept;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
  assign tx_ready  = (state == IDLE) || frame_end;
  assign tx_done   = frame_end;
  assign busy      = (state != IDLE);
  assign accept    = tx_valid && tx_ready;

  // Payload path: no reset needed, always reloaded on accept before it is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg  <= tx_data;
      parity_bit <= calc_parity(tx_data);
    end else if (state == DATA && bit_end) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  // tx is loaded with the value of the bit being entered, so it changes on the same edge as state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else if (state == IDLE) begin
      if (accept) begin
        state    <= START;
        baud_cnt <= '0;
        bit_idx  <= '0;
        tx       <= 1'b0;
      end
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if (bit_end) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end
          DATA: begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift_reg[1];
            end
          end
          PARITY: begin
            state   <= STOP;
            bit_idx <= '0;
            tx      <= 1'b1;
          end
          STOP: begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (accept) begin
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Parametrised UART transmit engine that succeeds the fixed 8-bit load/shift/select controller. It integrates the frame state machine, baud-rate divider, data shift register and parity generator into a single block. Data width, parity, stop-bit count and bit period are all configurable, and a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the transmit holding logic (or FIFO) and the serial `tx` pin.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 5–9.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN` = 0.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk` input 1: clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `tx_valid` input 1: `tx_data` holds a frame to send.
- `tx_data` input `DATA_W`: payload; bit 0 is transmitted first.
- `tx_ready` output 1: engine can accept a frame this cycle.
- `tx` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress.
- `tx_done` output 1: one-cycle pulse in the final clk of the last stop bit.

## Operation
- Reset values: `tx` = 1, `tx_ready` = 1, `busy` = 0, `tx_done` = 0; state = IDLE; counters = 0.
- Reset is asynchronous. Asserting it mid-frame forces `tx` high at once and abandons the frame; no partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept.
  - START → DATA after 1 bit period.
  - DATA → PARITY after `DATA_W` bit periods, or DATA → STOP when `PARITY_EN` = 0.
  - PARITY → STOP after 1 bit period.
  - STOP → START on accept in its final cycle; otherwise STOP → IDLE after `STOP_BITS` bit periods.
- Accept: `tx_valid` & `tx_ready` at a rising edge. On accept, `tx_data` is latched into the shift register and parity is computed from the latched value. Later changes to `tx_data` have no effect on the current frame.
- `tx_ready` is 1 in IDLE and in the final clk of the last stop bit; it is 0 at all other times.
- `tx` per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift-register bit 0; the register shifts right once per bit period.
  - PARITY: even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: 1.
- `tx` is registered, so there is no combinational path from inputs to `tx`.
- Baud counter counts 0..`CLKS_PER_BIT`−1 and wraps. The bit boundary is at terminal count.
- Bit-index counter counts 0..`DATA_W`−1 in DATA and 0..`STOP_BITS`−1 in STOP, and is cleared on each state change.
- Counter widths: $clog2(`CLKS_PER_BIT`) for the baud counter; $clog2(`DATA_W`+1) for the bit-index counter. Neither counter may overflow.
- `busy` = 1 in every state except IDLE.
- `tx_valid` asserted while `tx_ready` = 0 is ignored. The upstream must hold `tx_valid` until it sees the accept.

## Timing
- Latency: `tx` falls (start bit) in the first clk after the accepting edge.
- Frame length: (1 + `DATA_W` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` clks, exactly.
- Each bit is held for exactly `CLKS_PER_BIT` clks.
- Back-to-back: an accept in the last stop-bit clk starts the next start bit on the following clk. There is zero idle time; `tx_done` and `tx_ready` are both 1 in that clk.
- `busy` falls in the first IDLE clk, and only if no back-to-back accept occurred.

## Test plan
- Reset: hold `reset` = 0 with `tx_valid` = 1 → `tx` = 1, `tx_ready` = 1, `busy` = 0, `tx_done` = 0, and no frame starts until release.
- Even-parity frame: defaults with `CLKS_PER_BIT` = 4, send 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 clks (44 clks total); `tx_done` pulses at clk 44.
- Odd parity: `PARITY_ODD` = 1, send 0x01 → parity bit = 0; with `PARITY_ODD` = 0 → parity bit = 1.
- Back-to-back: hold `tx_valid` = 1 with 0x3C then 0xC3 → the second start bit directly follows the first stop bit with no high gap; `tx_ready` pulses exactly once between the frames; `busy` stays 1 throughout.
- Variant configuration: `DATA_W` = 7, `PARITY_EN` = 0, `STOP_BITS` = 2, send 0x55 → 10-bit frame 0,1,0,1,0,1,0,1,1,1, with `tx` high during both stop bits.
- Mid-frame reset: assert `reset` during data bit 3 → `tx` = 1 immediately; after release, a new 0xFF frame is sent cleanly with correct timing.
